prog_loader: RTL and testbench

- Boot-time program loader placed directly upstream of the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses from 0.
- Holds the core in reset until the whole image is written; after that the core's pc starts at 0 against a fully loaded memory.

---
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 126 ++++++++++++
 tb/tb_prog_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master is the stream source, which may also observe the memory writes.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: length-prefixed big-endian byte stream into
// instruction memory, holding the core in reset until the image is complete.
module prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          core_reset,
  output logic          done,
  output logic          error
);

  localparam logic [LEN_WIDTH:0] CAP_WORDS = (LEN_WIDTH+1)'(2**(ADDR_WIDTH-2));

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           len_hi, len_hi_nxt;
  logic [LEN_WIDTH-1:0] count, count_nxt;
  logic [LEN_WIDTH-1:0] word_idx, word_idx_nxt;
  logic [1:0]           byte_cnt, byte_cnt_nxt;
  logic [31:0]          wdata, wdata_nxt;
  logic [LEN_WIDTH-1:0] hdr_count;
  logic                 xfer;

  // in_ready and the write strobe are both masked by reset so nothing moves
  // on an edge where reset is low.
  assign bus.in_ready   = reset && (state == LEN_HI || state == LEN_LO || state == DATA);
  assign bus.imem_we    = reset && (state == WRITE);
  assign bus.imem_addr  = {word_idx[ADDR_WIDTH-3:0], 2'b00};
  assign bus.imem_wdata = wdata;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign hdr_count = LEN_WIDTH'({len_hi, bus.in_data});

  always_comb begin
    state_nxt    = state;
    len_hi_nxt   = len_hi;
    count_nxt    = count;
    word_idx_nxt = word_idx;
    byte_cnt_nxt = byte_cnt;
    wdata_nxt    = wdata;
    case (state)
      LEN_HI: begin
        if (xfer) begin
          len_hi_nxt = bus.in_data;
          state_nxt  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          count_nxt    = hdr_count;
          word_idx_nxt = '0;
          byte_cnt_nxt = '0;
          if (hdr_count == '0)
            state_nxt = DONE;
          else if ({1'b0, hdr_count} > CAP_WORDS)
            state_nxt = ERR;
          else
            state_nxt = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          wdata_nxt    = {wdata[23:0], bus.in_data};
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3)
            state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (word_idx == count - LEN_WIDTH'(1)) begin
          state_nxt = DONE;
        end else begin
          word_idx_nxt = word_idx + LEN_WIDTH'(1);
          state_nxt    = DATA;
        end
      end
      DONE, ERR: begin
        if (start) begin
          state_nxt    = LEN_HI;
          word_idx_nxt = '0;
          byte_cnt_nxt = '0;
        end
      end
      default: state_nxt = LEN_HI;
    endcase
  end

  // Status flags are registered from the next state so they line up with
  // the first cycle spent in DONE / ERR.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= LEN_HI;
      len_hi     <= '0;
      count      <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      wdata      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      state      <= state_nxt;
      len_hi     <= len_hi_nxt;
      count      <= count_nxt;
      word_idx   <= word_idx_nxt;
      byte_cnt   <= byte_cnt_nxt;
      wdata      <= wdata_nxt;
      done       <= (state_nxt == DONE);
      error      <= (state_nxt == ERR);
      core_reset <= (state_nxt != DONE);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table-driven loads plus hand sequences, with a
// write scoreboard fed by the stimulus and drained by a write monitor.
module tb_prog_loader;
  localparam int AW = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic core_reset, done, error;

  prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

  prog_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("wr_data", bus.imem_wdata, e.data);
        check1("ready_in_write", bus.in_ready, 1'b0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    if (g > 0) begin
      bus.in_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready %b want 1", bus.in_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_hdr(input logic [15:0] cnt, input int max_gap);
    send_byte(cnt[15:8], max_gap);
    send_byte(cnt[7:0], max_gap);
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input int max_gap);
    wr_t e;
    e.addr = AW'(idx * 4);
    e.data = w;
    exp_q.push_back(e);
    send_byte(w[31:24], max_gap);
    send_byte(w[23:16], max_gap);
    send_byte(w[15:8],  max_gap);
    send_byte(w[7:0],   max_gap);
    // the write lands in the cycle right after the 4th byte is taken
    check1("write_latency", bus.imem_we, 1'b1);
    check1("ready_low_write", bus.in_ready, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vecs[0] = '{16'd2,      32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0};
    vecs[1] = '{16'd0,      32'h0,        32'h0,        1'b1, 1'b0};
    vecs[2] = '{16'd257,    32'h0,        32'h0,        1'b0, 1'b1};
    vecs[3] = '{16'd1,      32'hCAFEF00D, 32'h0,        1'b1, 1'b0};
    vecs[4] = '{16'hFFFF,   32'h0,        32'h0,        1'b0, 1'b1};
    vecs[5] = '{16'd1,      32'h00000001, 32'h0,        1'b1, 1'b0};

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check1("rst_in_ready", bus.in_ready, 1'b0);
    check1("rst_core_reset", core_reset, 1'b1);
    check1("rst_done", done, 1'b0);
    check1("rst_error", error, 1'b0);
    check1("rst_we", bus.imem_we, 1'b0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check1("idle_in_ready", bus.in_ready, 1'b1);
    check1("idle_core_reset", core_reset, 1'b1);

    // table-driven loads, held-high stream
    for (int i = 0; i < 6; i++) begin
      if (i > 0) pulse_start();
      send_hdr(vecs[i].cnt, 0);
      if (!vecs[i].exp_err) begin
        for (int w = 0; w < int'(vecs[i].cnt); w++)
          send_word(w, (w == 0) ? vecs[i].w0 : vecs[i].w1, 0);
      end
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check1("vec_done", done, vecs[i].exp_done);
      check1("vec_error", error, vecs[i].exp_err);
      check1("vec_core_reset", core_reset, !vecs[i].exp_done);
      check1("vec_in_ready", bus.in_ready, 1'b0);
    end

    // zero count: DONE one cycle after the low count byte
    pulse_start();
    check1("restart_core_reset", core_reset, 1'b1);
    check1("restart_done", done, 1'b0);
    check1("restart_in_ready", bus.in_ready, 1'b1);
    send_hdr(16'h0000, 0);
    check1("zero_done", done, 1'b1);
    check1("zero_core_reset", core_reset, 1'b0);
    bus.in_valid = 1'b0;

    // oversize count: error, bytes not consumed, start clears it
    pulse_start();
    send_hdr(16'h0101, 0);
    check1("err_error", error, 1'b1);
    check1("err_core_reset", core_reset, 1'b1);
    check1("err_in_ready", bus.in_ready, 1'b0);
    bus.in_data = 8'h55;
    repeat (3) @(negedge clk);
    check1("err_hold_ready", bus.in_ready, 1'b0);
    check1("err_hold_error", error, 1'b1);
    bus.in_valid = 1'b0;
    pulse_start();
    check1("err_clr_error", error, 1'b0);
    check1("err_clr_ready", bus.in_ready, 1'b1);
    check1("err_clr_core_reset", core_reset, 1'b1);

    // full capacity with random gaps
    send_hdr(16'd256, 2);
    for (int w = 0; w < 256; w++)
      send_word(w, $urandom, 2);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check1("full_done", done, 1'b1);
    check1("full_core_reset", core_reset, 1'b0);

    // reset in the middle of the second word
    pulse_start();
    send_hdr(16'd2, 0);
    send_word(0, 32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check1("midrst_core_reset", core_reset, 1'b1);
    check1("midrst_done", done, 1'b0);
    check1("midrst_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    send_hdr(16'd1, 0);
    send_word(0, 32'hCAFEF00D, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check1("midrst_reload_done", done, 1'b1);

    // reload after DONE overwrites word 0
    pulse_start();
    check1("reload_core_reset", core_reset, 1'b1);
    check1("reload_done_low", done, 1'b0);
    send_hdr(16'd1, 1);
    send_word(0, 32'hAABBCCDD, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check1("reload_done", done, 1'b1);
    check1("reload_core_low", core_reset, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
